// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and the ALU_DIV_EN build switch shared by alu_seq and its core.
package alu_pkg;
   localparam logic [3:0] ALU_AND = 4'h0, ALU_OR = 4'h1, ALU_ADD = 4'h2, ALU_SUB = 4'h3,
                          ALU_SHR = 4'h4, ALU_SHL = 4'h5, ALU_ROR = 4'h6, ALU_ROL = 4'h7,
                          ALU_MUL = 4'h8, ALU_DIV = 4'h9, ALU_NEG = 4'hA, ALU_NOT = 4'hB;
   typedef enum logic [1:0] {IDLE, EXEC, ITER, FIX} alu_state_e;
`ifdef ALU_DIV_EN
   localparam bit ALU_HAS_DIV = 1'b1;
`else
   localparam bit ALU_HAS_DIV = 1'b0;
`endif
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/done request and result bus between the control unit (master) and alu_seq (slave).
interface alu_seq_if #(parameter int REG_SIZE = 32);
   logic                start;
   logic [3:0]          ctrl_sig;
   logic [REG_SIZE-1:0] y_data_in;
   logic [REG_SIZE-1:0] bus_data_in;
   logic                busy;
   logic                done;
   logic [REG_SIZE-1:0] z_lo;
   logic [REG_SIZE-1:0] z_hi;
   logic                div_zero;
   logic                illegal_op;
   modport master (output start, ctrl_sig, y_data_in, bus_data_in,
                   input  busy, done, z_lo, z_hi, div_zero, illegal_op);
   modport slave  (input  start, ctrl_sig, y_data_in, bus_data_in,
                   output busy, done, z_lo, z_hi, div_zero, illegal_op);
endinterface

// File: rtl/alu_muldiv_core.sv
// alu_muldiv_core: iterative shift-add multiplier and restoring divider on magnitudes, with sign fix-up.
// The divide path exists only when ALU_DIV_EN is defined (ALU_HAS_DIV folds it away otherwise).
module alu_muldiv_core import alu_pkg::*; #(parameter int W = 32) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         load,
   input  logic         is_div,
   input  logic         step,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         last,
   output logic         dz,
   output logic [W-1:0] res_hi,
   output logic [W-1:0] res_lo
);
   localparam int SW = $clog2(W);
   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
   logic [SW-1:0]  cnt_q, cnt_d;
   logic           div_q, div_d, sa_q, sa_d, sb_q, sb_d;
   logic [W:0]     sum, r2, diff;
   logic           ge, neg;
   logic [2*W-1:0] prod;
   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      return v[W-1] ? -v : v;
   endfunction
   // hi:lo is the product accumulator for mul, remainder:quotient for div; m is the other magnitude
   always_comb begin
      sum = {1'b0, hi_q} + {1'b0, m_q};
      r2 = {hi_q, lo_q[W-1]};
      diff = r2 - {1'b0, m_q};
      ge = r2 >= {1'b0, m_q};
      hi_d = hi_q;
      lo_d = lo_q;
      m_d = m_q;
      cnt_d = cnt_q;
      div_d = div_q;
      sa_d = sa_q;
      sb_d = sb_q;
      if (load) begin
         div_d = ALU_HAS_DIV && is_div;
         hi_d = '0;
         lo_d = div_d ? mag(a) : mag(b);
         m_d = div_d ? mag(b) : mag(a);
         cnt_d = '0;
         sa_d = a[W-1];
         sb_d = b[W-1];
      end else if (step) begin
         cnt_d = cnt_q + 1'b1;
         if (div_q) begin
            hi_d = ge ? diff[W-1:0] : r2[W-1:0];
            lo_d = {lo_q[W-2:0], ge};
         end else
            {hi_d, lo_d} = lo_q[0] ? {sum, lo_q[W-1:1]} : {1'b0, hi_q, lo_q[W-1:1]};
      end
   end
   // a zero divisor leaves the dividend magnitude as remainder, so only the quotient needs forcing
   assign last = step && (&cnt_q);
   assign neg = sa_q ^ sb_q;
   assign prod = neg ? -{hi_q, lo_q} : {hi_q, lo_q};
   assign dz = div_q && (m_q == '0);
   assign res_hi = div_q ? (sa_q ? -hi_q : hi_q) : prod[2*W-1:W];
   assign res_lo = dz ? '1 : div_q ? (neg ? -lo_q : lo_q) : prod[W-1:0];
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         hi_q <= '0;
         lo_q <= '0;
         m_q <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
         sa_q <= 1'b0;
         sb_q <= 1'b0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         m_q <= m_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
         sa_q <= sa_d;
         sb_q <= sb_d;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle 12-op ALU with start/done handshake; signed divide only when ALU_DIV_EN is defined.
module alu_seq import alu_pkg::*; #(parameter int REG_SIZE = 32) (
   input logic       clk,
   input logic       clr_n,
   alu_seq_if.slave  io
);
   localparam int SHAMT_W = $clog2(REG_SIZE);
   alu_state_e          state_q, state_d;
   logic                busy_q, busy_d, done_q, done_d, dz_q, dz_d, ill_q, ill_d;
   logic [REG_SIZE-1:0] z_lo_q, z_lo_d, z_hi_q, z_hi_d;
   logic [REG_SIZE-1:0] a, b, sc_res, core_hi, core_lo;
   logic [SHAMT_W-1:0]  sh;
   logic [SHAMT_W:0]    inv;
   logic [3:0]          op;
   logic                accept, is_div, is_md, sc_ill, core_last, core_dz;
   always_comb begin
      op = io.ctrl_sig;
      a = io.y_data_in;
      b = io.bus_data_in;
      sh = b[SHAMT_W-1:0];
      inv = (SHAMT_W+1)'(REG_SIZE) - {1'b0, sh};
      is_div = ALU_HAS_DIV && (op == ALU_DIV);
      is_md = (op == ALU_MUL) || is_div;
      accept = io.start && (!busy_q || done_q);
      sc_res = '0;
      sc_ill = 1'b0;
      case (op)
         ALU_AND: sc_res = a & b;
         ALU_OR:  sc_res = a | b;
         ALU_ADD: sc_res = a + b;
         ALU_SUB: sc_res = a - b;
         ALU_SHR: sc_res = a >> sh;
         ALU_SHL: sc_res = a << sh;
         ALU_ROR: sc_res = (a >> sh) | (a << inv);
         ALU_ROL: sc_res = (a << sh) | (a >> inv);
         ALU_NEG: sc_res = -b;
         ALU_NOT: sc_res = ~b;
         default: sc_ill = 1'b1;
      endcase
   end
   // the done cycle of a mul/div is back in IDLE with busy still set, so a new start is taken there
   always_comb begin
      state_d = state_q;
      busy_d = busy_q && !done_q;
      done_d = 1'b0;
      z_lo_d = z_lo_q;
      z_hi_d = z_hi_q;
      dz_d = dz_q;
      ill_d = ill_q;
      if (accept) begin
         state_d = is_md ? ITER : EXEC;
         busy_d = is_md;
         done_d = !is_md;
         if (!is_md) begin
            z_lo_d = sc_res;
            z_hi_d = '0;
            dz_d = 1'b0;
            ill_d = sc_ill;
         end
      end else if (state_q == ITER && core_last)
         state_d = FIX;
      else if (state_q == FIX) begin
         state_d = IDLE;
         done_d = 1'b1;
         z_lo_d = core_lo;
         z_hi_d = core_hi;
         dz_d = core_dz;
         ill_d = 1'b0;
      end else if (state_q == EXEC)
         state_d = IDLE;
   end
   alu_muldiv_core #(.W(REG_SIZE)) u_core (
      .clk    (clk),
      .clr_n  (clr_n),
      .load   (accept && is_md),
      .is_div (is_div),
      .step   (state_q == ITER),
      .a      (a),
      .b      (b),
      .last   (core_last),
      .dz     (core_dz),
      .res_hi (core_hi),
      .res_lo (core_lo)
   );
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         z_lo_q <= '0;
         z_hi_q <= '0;
         dz_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q <= busy_d;
         done_q <= done_d;
         z_lo_q <= z_lo_d;
         z_hi_q <= z_hi_d;
         dz_q <= dz_d;
         ill_q <= ill_d;
      end
   end
   assign io.busy = busy_q;
   assign io.done = done_q;
   assign io.z_lo = z_lo_q;
   assign io.z_hi = z_hi_q;
   assign io.div_zero = dz_q;
   assign io.illegal_op = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; divide expectations follow ALU_DIV_EN.
module tb_alu_seq;
   import alu_pkg::*;
   localparam int W = 32;
   localparam int N = 20;
   typedef struct {
      string        tag;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dz;
      logic         ill;
      logic         multi;
      int           issue;
      int           due;
   } exp_t;
   localparam logic [3:0] T_OP [N] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SHR, ALU_SHL, ALU_ROR,
      ALU_ROL, ALU_NEG, ALU_NOT, 4'hC, ALU_ADD, 4'hF, ALU_MUL, ALU_MUL, ALU_DIV, ALU_DIV, ALU_DIV,
      ALU_DIV, ALU_ADD};
   localparam logic [W-1:0] T_A [N] = '{32'hF0F0_1234, 32'h0000_00F0, 32'hFFFF_FFFF, 32'd3,
      32'h8000_0000, 32'd1, 32'd1, 32'h8000_0001, 32'd1234, 32'd0, 32'hAAAA_AAAA, 32'd2,
      32'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'd10, 32'hFFFF_FFEF, 32'd9, 32'h8000_0000, 32'd1};
   localparam logic [W-1:0] T_B [N] = '{32'hFF00_FF00, 32'h0F00_0000, 32'd1, 32'd5, 32'd4,
      32'd33, 32'd1, 32'd4, 32'd5, 32'h0F0F_0F0F, 32'h5555_5555, 32'd3, 32'd8, 32'h8000_0000,
      32'hFFFF_FFFF, 32'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1};
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   bit   mon_en = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   alu_seq_if #(.REG_SIZE(W)) bus ();
   alu_seq #(.REG_SIZE(W)) dut (.clk(clk), .clr_n(clr_n), .io(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   function automatic exp_t model(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa, sb, p;
      int     s;
      e.tag = tag;
      e.lo = '0;
      e.hi = '0;
      e.dz = 1'b0;
      e.ill = 1'b0;
      e.multi = 1'b0;
      e.issue = 0;
      e.due = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s = int'(b[4:0]);
      case (op)
         4'h0: e.lo = a & b;
         4'h1: e.lo = a | b;
         4'h2: e.lo = a + b;
         4'h3: e.lo = a - b;
         4'h4: e.lo = a >> s;
         4'h5: e.lo = a << s;
         4'h6: begin
            e.lo = a;
            for (int i = 0; i < s; i++) e.lo = {e.lo[0], e.lo[W-1:1]};
         end
         4'h7: begin
            e.lo = a;
            for (int i = 0; i < s; i++) e.lo = {e.lo[W-2:0], e.lo[W-1]};
         end
         4'h8: begin
            p = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.multi = 1'b1;
         end
         4'h9: begin
`ifdef ALU_DIV_EN
            e.multi = 1'b1;
            if (b == '0) begin
               e.lo = '1;
               e.hi = a;
               e.dz = 1'b1;
            end else begin
               p = sa / sb;
               e.lo = p[31:0];
               p = sa % sb;
               e.hi = p[31:0];
            end
`else
            e.ill = 1'b1;
`endif
         end
         4'hA: e.lo = -b;
         4'hB: e.lo = ~b;
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction
   task automatic drive(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit acc);
      exp_t e;
      e = model(tag, op, a, b);
      bus.start = 1'b1;
      bus.ctrl_sig = op;
      bus.y_data_in = a;
      bus.bus_data_in = b;
      if (acc) begin
         e.issue = cyc;
         e.due = cyc + (e.multi ? W + 2 : 1);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.ctrl_sig = 4'($urandom);
      bus.y_data_in = $urandom;
      bus.bus_data_in = $urandom;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain", 64'(q.size()), 64'd0);
      q.delete();
   endtask
   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      logic eb;
      if (mon_en && clr_n) begin
         eb = q.size() > 0 && q[0].multi && cyc > q[0].issue && cyc <= q[0].due;
         chk("busy", 64'(bus.busy), 64'(eb));
         if (bus.done || (q.size() > 0 && cyc >= q[0].due)) begin
            if (q.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
            else begin
               e = q.pop_front();
               chk({e.tag, "_cycle"}, 64'(cyc), 64'(e.due));
               chk({e.tag, "_done"}, 64'(bus.done), 64'd1);
               chk({e.tag, "_z_lo"}, 64'(bus.z_lo), 64'(e.lo));
               chk({e.tag, "_z_hi"}, 64'(bus.z_hi), 64'(e.hi));
               chk({e.tag, "_div_zero"}, 64'(bus.div_zero), 64'(e.dz));
               chk({e.tag, "_illegal"}, 64'(bus.illegal_op), 64'(e.ill));
            end
         end
      end
   end
   initial begin
      int d;
      bus.start = 1'b0;
      bus.ctrl_sig = '0;
      bus.y_data_in = '0;
      bus.bus_data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_z_lo", 64'(bus.z_lo), 64'd0);
      chk("rst_z_hi", 64'(bus.z_hi), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
      chk("rst_illegal", 64'(bus.illegal_op), 64'd0);
      clr_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      drive("add5_7", ALU_ADD, 32'd5, 32'd7, 1'b1);
      wait_idle();
      drive("mul_m3_7", ALU_MUL, 32'hFFFF_FFFD, 32'd7, 1'b1);
      d = q[0].due;
      drive("ign_add", ALU_ADD, 32'd1, 32'd1, 1'b0);
      drive("ign_mul", ALU_MUL, 32'd2, 32'd2, 1'b0);
      goto(d);
      drive("b2b_sub", ALU_SUB, 32'h10, 32'h20, 1'b1);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("hold_z_lo", 64'(bus.z_lo), 64'hFFFF_FFF0);
      chk("hold_z_hi", 64'(bus.z_hi), 64'd0);
      for (int i = 0; i < N; i++) begin
         drive($sformatf("t%0d_op%0h", i, T_OP[i]), T_OP[i], T_A[i], T_B[i], 1'b1);
         if (q[$].multi) wait_idle();
      end
      wait_idle();
      drive("mul_abort", ALU_MUL, 32'd123, 32'd456, 1'b1);
      goto(q[0].issue + 10);
      #1;
      clr_n = 1'b0;
      q.delete();
      #1;
      chk("abort_z_lo", 64'(bus.z_lo), 64'd0);
      chk("abort_z_hi", 64'(bus.z_hi), 64'd0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      @(posedge clk);
      #2;
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (40) @(posedge clk);
      #1;
      drive("add_after_abort", ALU_ADD, 32'd1, 32'd2, 1'b1);
      wait_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
